motor_step_sequencer: RTL and testbench

MOTOR_STEP_SEQUENCER -- requirements
Module: motor_step_sequencer

---
 rtl/motor_step_sequencer.sv | 115 +++++++++++
 tb/tb_motor_step_sequencer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/motor_step_sequencer.sv
// Two-phase bipolar stepper sequencer: counts CLK_DIV clocks per step and walks the
// full-step coil pattern forward or backward until the commanded step count is exhausted.
module motor_step_sequencer #(
   parameter int unsigned CLK_DIV = 50000,
   parameter int          CNT_W   = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [CNT_W-1:0] step_count,
   input  logic             dir,
   input  logic             load,
   input  logic             abort,
   input  logic             hold,
   output logic [1:0]       hb_a,
   output logic [1:0]       hb_b,
   output logic [CNT_W-1:0] remaining,
   output logic             dir_out,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam logic [31:0] DIV_MAX = 32'(CLK_DIV - 1);

   state_t           state_q, state_d;
   logic [1:0]       phase_q, phase_d;
   logic [31:0]      div_q, div_d;
   logic [CNT_W-1:0] rem_q, rem_d;
   logic             dir_q, dir_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [3:0]       hb_q, hb_d;

   function automatic logic [3:0] phase_pattern(input logic [1:0] p);
      case (p)
         2'd0:    phase_pattern = 4'b10_10;
         2'd1:    phase_pattern = 4'b01_10;
         2'd2:    phase_pattern = 4'b01_01;
         default: phase_pattern = 4'b10_01;
      endcase
   endfunction

   // Abort beats load; load in IDLE starts a move, load in RUN retargets it without touching phase.
   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      div_d   = div_q;
      rem_d   = rem_q;
      dir_d   = dir_q;

      if (state_q == DONE) begin
         state_d = IDLE;
      end else if (state_q == RUN && abort) begin
         state_d = IDLE;
      end else if (load && !abort) begin
         dir_d = dir;
         div_d = '0;
         if (step_count != '0) begin
            rem_d   = step_count;
            state_d = RUN;
         end else begin
            rem_d   = '0;
            state_d = DONE;
         end
      end else if (state_q == RUN) begin
         if (div_q >= DIV_MAX) begin
            div_d   = '0;
            phase_d = dir_q ? phase_q + 2'd1 : phase_q - 2'd1;
            if (rem_q != '0) begin
               rem_d = rem_q - CNT_W'(1);
            end
            if (rem_q <= CNT_W'(1)) begin
               state_d = DONE;
            end
         end else begin
            div_d = div_q + 32'd1;
         end
      end

      busy_d = (state_d == RUN);
      done_d = (state_d == DONE);
      hb_d   = (busy_d || done_d || hold) ? phase_pattern(phase_d) : 4'b00_00;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         phase_q <= 2'd0;
         div_q   <= '0;
         rem_q   <= '0;
         dir_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         hb_q    <= 4'b00_00;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         div_q   <= div_d;
         rem_q   <= rem_d;
         dir_q   <= dir_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         hb_q    <= hb_d;
      end
   end

   assign hb_a      = hb_q[3:2];
   assign hb_b      = hb_q[1:0];
   assign remaining = rem_q;
   assign dir_out   = dir_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_motor_step_sequencer.sv
// Directed bench for motor_step_sequencer at CLK_DIV=4: reset, forward/reverse runs,
// zero-count load, abort with a colliding load, and reset in the middle of a run.
module tb_motor_step_sequencer;

   localparam int CD = 4;
   localparam int CW = 32;

   logic          clk;
   logic          reset;
   logic [CW-1:0] step_count;
   logic          dir;
   logic          load;
   logic          abort;
   logic          hold;
   logic [1:0]    hb_a;
   logic [1:0]    hb_b;
   logic [CW-1:0] remaining;
   logic          dir_out;
   logic          busy;
   logic          done;

   int n_checks;
   int n_pass;
   int busy_cycles;
   int done_pulses;
   logic [3:0] pat [4];

   motor_step_sequencer #(.CLK_DIV(CD), .CNT_W(CW)) dut (
      .clk        (clk),
      .reset      (reset),
      .step_count (step_count),
      .dir        (dir),
      .load       (load),
      .abort      (abort),
      .hold       (hold),
      .hb_a       (hb_a),
      .hb_b       (hb_b),
      .remaining  (remaining),
      .dir_out    (dir_out),
      .busy       (busy),
      .done       (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual === expected) begin
         n_pass++;
      end else begin
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Advance one clock and sample 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_load(input logic [CW-1:0] cnt, input logic d);
      step_count = cnt;
      dir        = d;
      load       = 1'b1;
      tick();
      load       = 1'b0;
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      pat[0] = 4'b1010;
      pat[1] = 4'b0110;
      pat[2] = 4'b0101;
      pat[3] = 4'b1001;

      reset      = 1'b0;
      step_count = '0;
      dir        = 1'b0;
      load       = 1'b0;
      abort      = 1'b0;
      hold       = 1'b1;

      // Reset held for three cycles with hold=1.
      repeat (3) tick();
      check_output("rst_hb",   {28'd0, hb_a, hb_b}, 32'h0);
      check_output("rst_busy", {31'd0, busy}, 32'd0);
      check_output("rst_done", {31'd0, done}, 32'd0);
      check_output("rst_rem",  remaining, 32'd0);
      check_output("rst_dir",  {31'd0, dir_out}, 32'd0);
      reset = 1'b1;
      tick();
      check_output("idle_hold_hb", {28'd0, hb_a, hb_b}, {28'd0, pat[0]});

      // Forward run of 5 steps with hold off.
      hold = 1'b0;
      tick();
      check_output("idle_nohold_hb", {28'd0, hb_a, hb_b}, 32'h0);
      apply_load(32'd5, 1'b1);
      check_output("fwd_rem0", remaining, 32'd5);
      check_output("fwd_dir",  {31'd0, dir_out}, 32'd1);
      check_output("fwd_hb0",  {28'd0, hb_a, hb_b}, {28'd0, pat[0]});
      busy_cycles = int'(busy);
      done_pulses = 0;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (i < 20) busy_cycles += int'(busy);
         done_pulses += int'(done);
         if (i % CD == 0) begin
            check_output($sformatf("fwd_hb_step%0d", i / CD), {28'd0, hb_a, hb_b}, {28'd0, pat[(i / CD) % 4]});
            check_output($sformatf("fwd_rem_step%0d", i / CD), remaining, 32'(5 - i / CD));
         end
      end
      check_output("fwd_busy_cycles", 32'(busy_cycles), 32'd20);
      check_output("fwd_busy_end", {31'd0, busy}, 32'd0);
      check_output("fwd_done_end", {31'd0, done}, 32'd1);
      tick();
      done_pulses += int'(done);
      check_output("fwd_done_pulses", 32'(done_pulses), 32'd1);
      check_output("fwd_after_hb", {28'd0, hb_a, hb_b}, 32'h0);

      // Return to phase 0, then a 3-step reverse run with hold on.
      reset = 1'b0;
      tick();
      reset = 1'b1;
      hold  = 1'b1;
      tick();
      apply_load(32'd3, 1'b0);
      check_output("rev_dir", {31'd0, dir_out}, 32'd0);
      check_output("rev_rem0", remaining, 32'd3);
      done_pulses = 0;
      for (int i = 1; i <= 12; i++) begin
         tick();
         done_pulses += int'(done);
         if (i % CD == 0) begin
            check_output($sformatf("rev_hb_step%0d", i / CD), {28'd0, hb_a, hb_b}, {28'd0, pat[(4 - i / CD) % 4]});
            check_output($sformatf("rev_rem_step%0d", i / CD), remaining, 32'(3 - i / CD));
         end
      end
      tick();
      done_pulses += int'(done);
      check_output("rev_done_pulses", 32'(done_pulses), 32'd1);
      check_output("rev_hold_hb", {28'd0, hb_a, hb_b}, {28'd0, pat[1]});

      // Zero-count load goes straight to DONE without moving.
      apply_load(32'd0, 1'b1);
      check_output("zero_busy", {31'd0, busy}, 32'd0);
      check_output("zero_done", {31'd0, done}, 32'd1);
      check_output("zero_rem",  remaining, 32'd0);
      check_output("zero_hb",   {28'd0, hb_a, hb_b}, {28'd0, pat[1]});
      tick();
      check_output("zero_done_clr", {31'd0, done}, 32'd0);

      // Abort after 2 of 10 steps, colliding with a load that must be ignored.
      hold = 1'b0;
      apply_load(32'd10, 1'b1);
      done_pulses = 0;
      repeat (2 * CD) begin
         tick();
         done_pulses += int'(done);
      end
      check_output("abort_pre_rem", remaining, 32'd8);
      abort      = 1'b1;
      load       = 1'b1;
      step_count = 32'd2;
      dir        = 1'b0;
      tick();
      abort = 1'b0;
      load  = 1'b0;
      done_pulses += int'(done);
      check_output("abort_busy", {31'd0, busy}, 32'd0);
      check_output("abort_rem",  remaining, 32'd8);
      check_output("abort_dir",  {31'd0, dir_out}, 32'd1);
      check_output("abort_hb",   {28'd0, hb_a, hb_b}, 32'h0);
      hold = 1'b1;
      repeat (3) begin
         tick();
         done_pulses += int'(done);
      end
      check_output("abort_no_done", 32'(done_pulses), 32'd0);
      check_output("abort_phase_kept", {28'd0, hb_a, hb_b}, {28'd0, pat[3]});

      // Reset in the middle of a run clears everything asynchronously.
      hold = 1'b0;
      apply_load(32'd3, 1'b1);
      check_output("mid_rem", remaining, 32'd3);
      check_output("mid_busy", {31'd0, busy}, 32'd1);
      reset = 1'b0;
      #1;
      check_output("mid_rst_busy", {31'd0, busy}, 32'd0);
      check_output("mid_rst_rem",  remaining, 32'd0);
      check_output("mid_rst_hb",   {28'd0, hb_a, hb_b}, 32'h0);
      check_output("mid_rst_dir",  {31'd0, dir_out}, 32'd0);
      tick();
      reset = 1'b1;
      done_pulses = 0;
      busy_cycles = 0;
      repeat (20) begin
         tick();
         done_pulses += int'(done);
         busy_cycles += int'(busy);
      end
      check_output("mid_no_done", 32'(done_pulses), 32'd0);
      check_output("mid_no_busy", 32'(busy_cycles), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
